// File: rtl/tap3_smooth_reader.sv
// Sweeps a three-read-port RAM in index order and streams the 1-2-1 smoothed
// value of each entry over a valid/ready handshake.
module tap3_smooth_reader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [ADDR_W-1:0] ram_addr2,
    input  logic [DATA_W-1:0] ram_data0,
    input  logic [DATA_W-1:0] ram_data1,
    input  logic [DATA_W-1:0] ram_data2,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] p_idx_reg;
    logic              p_valid_reg;
    logic              p_first_reg;
    logic              p_end_reg;

    logic              adv;
    logic              in_run;
    logic [DATA_W-1:0] tap_l;
    logic [DATA_W-1:0] tap_r;
    logic [DATA_W+1:0] sum;

    // One beat is in flight at most; a stall freezes both the RAM and the output.
    assign adv    = !out_valid || out_ready;
    assign in_run = (state_reg == RUN);
    assign busy   = (state_reg != IDLE);
    assign ram_ce = in_run && adv;
    assign ram_we = 1'b0;

    assign ram_addr1 = in_run ? idx_reg : '0;
    assign ram_addr0 = (in_run && idx_reg != '0) ? idx_reg - ADDR_W'(1) : '0;
    assign ram_addr2 = !in_run ? '0 : (idx_reg == LAST_IDX) ? LAST_IDX : idx_reg + ADDR_W'(1);

    // Edge flags travel with the RAM read so they line up with the returned data.
    assign tap_l = (EDGE_MODE != 0 && p_first_reg) ? '0 : ram_data0;
    assign tap_r = (EDGE_MODE != 0 && p_end_reg)   ? '0 : ram_data2;
    assign sum   = {2'b00, tap_l} + {1'b0, ram_data1, 1'b0} + {2'b00, tap_r} + (DATA_W+2)'(2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            p_idx_reg   <= '0;
            p_valid_reg <= 1'b0;
            p_first_reg <= 1'b0;
            p_end_reg   <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (adv && p_valid_reg) begin
                out_valid <= 1'b1;
                out_data  <= sum[DATA_W+1:2];
                out_idx   <= p_idx_reg;
                out_last  <= p_end_reg;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    if (adv) begin
                        p_idx_reg   <= idx_reg;
                        p_first_reg <= (idx_reg == '0);
                        p_end_reg   <= (idx_reg == LAST_IDX);
                        p_valid_reg <= 1'b1;
                        idx_reg     <= idx_reg + ADDR_W'(1);
                        if (idx_reg == LAST_IDX)
                            state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (adv)
                        p_valid_reg <= 1'b0;
                    if (out_valid && out_ready && out_last) begin
                        state_reg <= IDLE;
                        done      <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tap3_smooth_reader.md
Name: tap3_smooth_reader

Overview:
- Downstream consumer of the 16x8 three-read-port register RAM.
- On `start`, sweeps all entries in index order 0..15. For each index it reads left, centre and right neighbours in one RAM access, applies a 1-2-1 smoothing kernel, and streams the results to the LCD pixel path over a valid/ready handshake.
- Owns the RAM port for the duration of a sweep.

Parameters:
- ADDR_W, 4, RAM address width; entry count N = 2**ADDR_W.
- DATA_W, 8, RAM/result data width.
- EDGE_MODE, 0, out-of-range neighbour handling: 0 = clamp to nearest valid index, 1 = treat as zero.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse on the cycle after the last result is accepted.
- ram_ce  out  1  RAM chip enable; low holds the RAM address registers.
- ram_we  out  1  RAM write enable; constant 0.
- ram_addr0  out  ADDR_W  left neighbour address (idx-1, clamped).
- ram_addr1  out  ADDR_W  centre address (idx).
- ram_addr2  out  ADDR_W  right neighbour address (idx+1, clamped).
- ram_data0  in  DATA_W  RAM read data for addr0, valid the cycle after ce-sampled issue.
- ram_data1  in  DATA_W  RAM read data for addr1, with the same timing as ram_data0.
- ram_data2  in  DATA_W  RAM read data for addr2, with the same timing as ram_data0.
- out_data  out  DATA_W  smoothed result.
- out_idx  out  ADDR_W  index of out_data.
- out_last  out  1  high with idx N-1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0, ram_ce=0, ram_addr*=0, issue index=0, pipeline flag p_valid=0. Reset mid-sweep aborts the sweep; no done is produced.
- States:
  - IDLE: start=1 goes to RUN with issue index=0.
  - RUN: issues addresses; after index N-1 is issued, goes to DRAIN.
  - DRAIN: waits for the final result; on acceptance of the out_last beat, goes to IDLE and pulses done.
- Advance condition: adv = !out_valid || out_ready.
- ram_ce = (state==RUN) && adv. A stall holds ram_ce=0, so RAM address registers and read data stay stable with no replay needed.
- In RUN when adv: drive addresses for the issue index, increment the index, set p_valid=1, and register idx and edge flags in step with the RAM.
- In DRAIN when adv: clear p_valid after the final load.
- Output register loads when adv && p_valid: out_valid=1, with out_data/out_idx/out_last from the in-flight beat. It clears out_valid when out_ready=1 and nothing loads.
- Latency: start edge to first out_valid = 2 cycles. Throughput = 1 result/cycle while out_ready=1.
- Edge addressing: idx 0 drives addr0=0; idx N-1 drives addr2=N-1.
- Edge values:
  - EDGE_MODE=1: the out-of-range neighbour value is forced to 0 using the registered edge flag.
  - EDGE_MODE=0: the clamped RAM value is used.
- Arithmetic: sum = a + 2b + c + 2, width DATA_W+2 (max 1022 fits in 10 bits). out_data = sum >> 2. No saturation is needed.
- Start while busy is ignored. Start in the same cycle as done is accepted (IDLE is entered first, so start is sampled next cycle).
- out_ready may toggle on any cycle. Data must not change while out_valid=1 && out_ready=0.
- The block never writes the RAM; external writers must not touch the RAM while busy=1.

Test Plan:
- RAM mem[i]=16*i, EDGE_MODE=0, out_ready=1:
  - 16 beats on consecutive cycles starting 2 cycles after start.
  - idx0 out_data=4, idx5 out_data=80, idx15 out_data=236.
  - out_last only on idx15; done one cycle after it.
- All entries 0xFF:
  - EDGE_MODE=0 → every beat 255.
  - EDGE_MODE=1 → idx0 and idx15 = 191, others 255.
- Backpressure: out_ready low for 3 cycles while holding idx4.
  - out_data/out_idx stable for those cycles; ram_ce=0 throughout.
  - The sequence resumes with idx5 the next cycle; no beat is lost or duplicated.
- rst_n low for 1 cycle at idx8 mid-sweep:
  - All outputs return to reset values next cycle; no done pulse.
  - A new start gives a full sweep from idx0.
- start pulsed repeatedly while busy=1: ignored, exactly 16 beats and one done. After done, a fresh start runs a second full sweep.
